// File: rtl/window_column_feeder_if.sv
// ---------------------------------------------------------------------------
// window_column_feeder_if
//  Pixel-in / column-out bundle for the raster-to-column feeder.
//  Upstream side : in_valid, in_data, in_ready (valid/ready handshake).
//  Downstream    : out_enable, out_data, out_line_last, out_frame_last
//                  (streaming enable/data pair for the window generator).
//  master modport: the pixel source / column sink (testbench side).
//  slave  modport: the feeder itself.
// ---------------------------------------------------------------------------
interface window_column_feeder_if #(
   parameter int color_width  = 12,
   parameter int window_width = 3
);
   logic                                  in_valid;
   logic [color_width-1:0]                in_data;
   logic                                  in_ready;
   logic                                  out_enable;
   logic [color_width*window_width-1:0]   out_data;
   logic                                  out_line_last;
   logic                                  out_frame_last;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  out_enable,
      input  out_data,
      input  out_line_last,
      input  out_frame_last
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output out_enable,
      output out_data,
      output out_line_last,
      output out_frame_last
   );
endinterface

// File: rtl/window_column_feeder.sv
// ---------------------------------------------------------------------------
// window_column_feeder
//  Raster-to-column front end for the window generator. Takes one pixel per
//  handshake in raster order, keeps the previous window_width-1 lines in line
//  buffers and, once enough lines are stored, emits one registered vertical
//  column of window_width pixels per accepted pixel.
//
//  Ports
//   clk    : clock, rising edge
//   rst_n  : asynchronous reset, active low
//   bus    : window_column_feeder_if.slave
//            in_valid/in_data/in_ready   pixel handshake
//            out_enable/out_data         column stream (row y at bits
//                                        [(y+1)*cw-1 : y*cw], y=0 oldest)
//            out_line_last               last column of a line
//            out_frame_last              last column of a frame
//
//  state  | meaning
//  -------+---------------------------------------------------------------
//  FILL   | rows 0..ww-2 of a frame: pixels go into the buffers only
//  STREAM | rows ww-1..im_height-1: every accepted pixel emits a column
//  GAP    | one dead cycle after each line, in_ready low, so out_enable
//         | is low between lines and the window generator restarts
// ---------------------------------------------------------------------------
module window_column_feeder #(
   parameter int color_width  = 12,
   parameter int window_width = 3,
   parameter int im_width     = 320,
   parameter int im_height    = 240,
   parameter int col_bits     = 9,
   parameter int row_bits     = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   window_column_feeder_if.slave   bus
);

   localparam int column_width = color_width * window_width;
   localparam int num_lines    = window_width - 1;

   localparam logic [col_bits-1:0] col_last     = col_bits'(im_width - 1);
   localparam logic [row_bits-1:0] row_last     = row_bits'(im_height - 1);
   localparam logic [row_bits-1:0] row_stream   = row_bits'(window_width - 1);

   typedef enum logic [1:0] {
      FILL   = 2'd0,
      STREAM = 2'd1,
      GAP    = 2'd2
   } state_t;

   state_t                    state_q;
   state_t                    state_d;
   logic                      ready_q;
   logic                      ready_d;

   logic [col_bits-1:0]       col_cnt;
   logic [row_bits-1:0]       row_cnt;

   logic                      accept;
   logic                      emit;
   logic                      at_col_last;
   logic                      at_row_last;

   logic [color_width-1:0]    line_mem [num_lines][im_width];
   logic [column_width-1:0]   column;

   logic                      enable_q;
   logic [column_width-1:0]   data_q;
   logic                      line_last_q;
   logic                      frame_last_q;

   assign bus.in_ready       = ready_q;
   assign bus.out_enable     = enable_q;
   assign bus.out_data       = data_q;
   assign bus.out_line_last  = line_last_q;
   assign bus.out_frame_last = frame_last_q;

   // ready_q is never high in GAP; the state term only guards against
   // accepting on a corrupted ready flop.
   assign accept      = bus.in_valid & ready_q & (state_q != GAP);
   assign emit        = accept & (state_q == STREAM);
   assign at_col_last = (col_cnt == col_last);
   assign at_row_last = (row_cnt == row_last);

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FILL;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
      end
   end

   // row_cnt has already advanced when GAP is reached, so it names the
   // line that comes next; row 0 after a frame wrap lands back in FILL.
   always_comb begin
      state_d = state_q;
      case (state_q)
         FILL, STREAM: begin
            if (accept && at_col_last) begin
               state_d = GAP;
            end
         end
         GAP: begin
            if (row_cnt < row_stream) begin
               state_d = FILL;
            end else begin
               state_d = STREAM;
            end
         end
         default: state_d = FILL;
      endcase
      ready_d = (state_d != GAP);
   end

   // ------------------------------------------------------------------
   // Raster position
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_cnt <= '0;
         row_cnt <= '0;
      end else if (accept) begin
         if (at_col_last) begin
            col_cnt <= '0;
            if (at_row_last) begin
               row_cnt <= '0;
            end else begin
               row_cnt <= row_cnt + row_bits'(1);
            end
         end else begin
            col_cnt <= col_cnt + col_bits'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Line buffers: line_mem[0] holds the oldest stored row. The column is
   // assembled from the old contents before the shift below lands.
   // ------------------------------------------------------------------
   always_comb begin
      column = '0;
      for (int k = 0; k < num_lines; k++) begin
         column[k*color_width +: color_width] = line_mem[k][col_cnt];
      end
      column[num_lines*color_width +: color_width] = bus.in_data;
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         for (int k = 0; k < num_lines - 1; k++) begin
            line_mem[k][col_cnt] <= line_mem[k+1][col_cnt];
         end
         line_mem[num_lines-1][col_cnt] <= bus.in_data;
      end
   end

   // ------------------------------------------------------------------
   // Registered column output; data holds between emitted columns.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enable_q     <= 1'b0;
         data_q       <= '0;
         line_last_q  <= 1'b0;
         frame_last_q <= 1'b0;
      end else begin
         enable_q     <= emit;
         line_last_q  <= emit & at_col_last;
         frame_last_q <= emit & at_col_last & at_row_last;
         if (emit) begin
            data_q <= column;
         end
      end
   end

endmodule

// File: tb/tb_window_column_feeder.sv
module tb_window_column_feeder;

   localparam int CW = 12;
   localparam int WW = 3;
   localparam int W  = 4;
   localparam int H  = 4;
   localparam int DW = CW * WW;

   logic clk;
   logic rst_n;

   window_column_feeder_if #(.color_width(CW), .window_width(WW)) bus ();

   window_column_feeder #(
      .color_width (CW),
      .window_width(WW),
      .im_width    (W),
      .im_height   (H),
      .col_bits    (2),
      .row_bits    (2)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // reference model: whole-frame image plus raster position
   logic [CW-1:0] img [H][W];
   int            m_row;
   int            m_col;
   logic          m_ready;
   logic          e_en;
   logic [DW-1:0] e_data;
   logic          e_ll;
   logic          e_fl;

   typedef struct packed {
      logic          v;
      logic [CW-1:0] d;
      logic          rdy;
      logic          en;
      logic [DW-1:0] data;
      logic          ll;
      logic          fl;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
      end
   endtask

   task automatic add(input logic v, input logic [CW-1:0] d, input logic rdy,
                      input logic en, input logic [DW-1:0] data, input logic ll,
                      input logic fl);
      vq.push_back('{v: v, d: d, rdy: rdy, en: en, data: data, ll: ll, fl: fl});
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "_ready"},      64'(bus.in_ready),       64'(m_ready));
      chk({tag, "_enable"},     64'(bus.out_enable),     64'(e_en));
      chk({tag, "_data"},       64'(bus.out_data),       64'(e_data));
      chk({tag, "_line_last"},  64'(bus.out_line_last),  64'(e_ll));
      chk({tag, "_frame_last"}, 64'(bus.out_frame_last), 64'(e_fl));
   endtask

   // asserts reset at a negedge, checks the asynchronous clear, releases
   // it two cycles later and resets the model; returns at a negedge
   task automatic do_reset();
      @(negedge clk);
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      chk("rst_ready",      64'(bus.in_ready),       64'd0);
      chk("rst_enable",     64'(bus.out_enable),     64'd0);
      chk("rst_data",       64'(bus.out_data),       64'd0);
      chk("rst_line_last",  64'(bus.out_line_last),  64'd0);
      chk("rst_frame_last", 64'(bus.out_frame_last), 64'd0);
      repeat (2) @(negedge clk);
      rst_n   = 1'b1;
      m_row   = 0;
      m_col   = 0;
      m_ready = 1'b0;
      e_en    = 1'b0;
      e_data  = '0;
      e_ll    = 1'b0;
      e_fl    = 1'b0;
      chk("release_ready", 64'(bus.in_ready), 64'd0);
   endtask

   // one cycle: drive at a negedge, predict, check at the next negedge
   task automatic step(input logic v, input logic [CW-1:0] d, input string tag);
      logic acc;
      bus.in_valid = v;
      bus.in_data  = d;
      acc  = v && m_ready;
      e_en = 1'b0;
      e_ll = 1'b0;
      e_fl = 1'b0;
      if (acc) begin
         img[m_row][m_col] = d;
         if (m_row >= WW - 1) begin
            e_en = 1'b1;
            for (int y = 0; y < WW; y++) begin
               e_data[y*CW +: CW] = img[m_row - WW + 1 + y][m_col];
            end
            e_ll = (m_col == W - 1);
            e_fl = e_ll && (m_row == H - 1);
         end
         m_ready = (m_col != W - 1);
         if (m_col == W - 1) begin
            m_col = 0;
            m_row = (m_row + 1) % H;
         end else begin
            m_col++;
         end
      end else begin
         m_ready = 1'b1;
      end
      @(negedge clk);
      check_outputs(tag);
   endtask

   function automatic logic [CW-1:0] pat();
      return CW'(m_row * 16 + m_col);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int drops;
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;

      // ---------------- directed frame table ----------------
      add(1, 12'h000, 1, 0, 36'h0,           0, 0);
      add(1, 12'h000, 1, 0, 36'h0,           0, 0);
      add(1, 12'h001, 1, 0, 36'h0,           0, 0);
      add(1, 12'h002, 1, 0, 36'h0,           0, 0);
      add(1, 12'h003, 0, 0, 36'h0,           0, 0);
      add(1, 12'h010, 1, 0, 36'h0,           0, 0);
      add(1, 12'h010, 1, 0, 36'h0,           0, 0);
      add(1, 12'h011, 1, 0, 36'h0,           0, 0);
      add(1, 12'h012, 1, 0, 36'h0,           0, 0);
      add(1, 12'h013, 0, 0, 36'h0,           0, 0);
      add(1, 12'h020, 1, 0, 36'h0,           0, 0);
      add(1, 12'h020, 1, 1, 36'h020_010_000, 0, 0);
      add(1, 12'h021, 1, 1, 36'h021_011_001, 0, 0);
      add(1, 12'h022, 1, 1, 36'h022_012_002, 0, 0);
      add(1, 12'h023, 0, 1, 36'h023_013_003, 1, 0);
      add(1, 12'h030, 1, 0, 36'h023_013_003, 0, 0);
      add(1, 12'h030, 1, 1, 36'h030_020_010, 0, 0);
      add(1, 12'h031, 1, 1, 36'h031_021_011, 0, 0);
      add(1, 12'h032, 1, 1, 36'h032_022_012, 0, 0);
      add(1, 12'h033, 0, 1, 36'h033_023_013, 1, 1);
      add(1, 12'h000, 1, 0, 36'h033_023_013, 0, 0);
      add(1, 12'h000, 1, 0, 36'h033_023_013, 0, 0);
      add(1, 12'h001, 1, 0, 36'h033_023_013, 0, 0);
      add(1, 12'h002, 1, 0, 36'h033_023_013, 0, 0);
      add(1, 12'h003, 0, 0, 36'h033_023_013, 0, 0);

      do_reset();
      for (int i = 0; i < vq.size(); i++) begin
         bus.in_valid = vq[i].v;
         bus.in_data  = vq[i].d;
         @(negedge clk);
         chk($sformatf("tbl%0d_ready", i),      64'(bus.in_ready),       64'(vq[i].rdy));
         chk($sformatf("tbl%0d_enable", i),     64'(bus.out_enable),     64'(vq[i].en));
         chk($sformatf("tbl%0d_data", i),       64'(bus.out_data),       64'(vq[i].data));
         chk($sformatf("tbl%0d_line_last", i),  64'(bus.out_line_last),  64'(vq[i].ll));
         chk($sformatf("tbl%0d_frame_last", i), 64'(bus.out_frame_last), 64'(vq[i].fl));
      end

      // ---------------- in_valid low two cycles mid row 3 ----------------
      do_reset();
      drops = 0;
      for (int i = 0; i < 40; i++) begin
         if (m_row == 3 && m_col == 2 && drops < 2) begin
            drops++;
            step(1'b0, pat(), "drop");
            chk("drop_enable_low", 64'(bus.out_enable), 64'd0);
         end else if (m_row == 3 && m_col == 2 && m_ready) begin
            step(1'b1, pat(), "resume");
            chk("resume_column", 64'(bus.out_data), 64'h032_022_012);
         end else begin
            step(1'b1, pat(), "drop_seq");
         end
      end

      // ---------------- reset pulse mid row 2 ----------------
      do_reset();
      for (int i = 0; i < 30; i++) begin
         if (m_row == 2 && m_col == 2) break;
         step(1'b1, pat(), "pre_rst");
      end
      chk("pre_rst_enable", 64'(bus.out_enable), 64'd1);
      do_reset();
      for (int i = 0; i < 30; i++) begin
         step(1'b1, pat(), "post_rst");
      end

      // ---------------- randomized traffic ----------------
      do_reset();
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 3) != 0), CW'($urandom_range(0, 4095)), "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
